// File: rtl/instr_fetch.sv
// instr_fetch: KGP-RISC fetch stage between the pc register and decode.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned PCs in ERR instead of word-aligning them.
module instr_fetch #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_in,
   output logic              pc_en,
   input  logic              redirect,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              fetch_err
);
`ifdef FETCH_ALIGN_CHECK_EN
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, HOLD, ERR} state_t;
`else
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, HOLD} state_t;
`endif
   state_t state, nxt;
   logic [ADDR_W-1:0] req_pc;
   logic capture;
   assign imem_req = state == WAIT || state == DRAIN;
   assign instr_valid = state == HOLD;
   assign capture = state == WAIT && imem_ack && !redirect;
   assign pc_en = capture;
`ifdef FETCH_ALIGN_CHECK_EN
   assign imem_addr = req_pc;
   assign fetch_err = state == ERR;
`else
   assign imem_addr = {req_pc[ADDR_W-1:2], 2'b00};
   assign fetch_err = 1'b0;
`endif
   // a redirect in ISSUE means pc_in is still the old value, so sampling waits a cycle
   always_comb begin
      nxt = state;
      case (state)
         IDLE:  nxt = ISSUE;
`ifdef FETCH_ALIGN_CHECK_EN
         ISSUE: nxt = redirect ? ISSUE : (|pc_in[1:0]) ? ERR : WAIT;
         ERR:   nxt = redirect ? ISSUE : ERR;
`else
         ISSUE: nxt = redirect ? ISSUE : WAIT;
`endif
         WAIT:  nxt = imem_ack ? (redirect ? ISSUE : HOLD) : (redirect ? DRAIN : WAIT);
         DRAIN: nxt = imem_ack ? ISSUE : DRAIN;
         HOLD:  nxt = (instr_ready || redirect) ? ISSUE : HOLD;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         req_pc   <= '0;
         instr    <= '0;
         instr_pc <= '0;
      end else begin
         state <= nxt;
         if (state == ISSUE && !redirect) req_pc <= pc_in;
         if (capture) begin
            instr    <= imem_rdata;
            instr_pc <= req_pc;
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus randomized traffic against a program-order PC model.
module tb_instr_fetch;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic redirect, instr_ready, pc_en, imem_req, imem_ack, instr_valid, fetch_err;
   logic [31:0] pc, target, rst_pc, imem_addr, imem_rdata, instr, instr_pc;
   int lat = 0;
   int wait_cnt;
   int n_cmp = 0, n_err = 0;
   logic h_req[64], h_valid[64], h_pcen[64], h_ferr[64];
   logic [31:0] h_addr[64], h_ipc[64], h_instr[64];

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // environment: pc register with add4, and a memory acking after lat pending cycles
   always @(posedge clk or posedge rst)
      if (rst) pc <= rst_pc;
      else if (redirect) pc <= target;
      else if (pc_en) pc <= pc + 32'd4;
   always @(posedge clk or posedge rst)
      if (rst || !imem_req || imem_ack) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   assign imem_ack = imem_req && (wait_cnt >= lat);
   assign imem_rdata = mem_word(imem_addr);

   instr_fetch dut (
      .clk(clk), .rst(rst), .pc_in(pc), .pc_en(pc_en), .redirect(redirect),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .fetch_err(fetch_err)
   );

   task automatic do_reset(input logic [31:0] pc0);
      @(negedge clk);
      rst_pc = pc0;
      rst = 1'b1;
      redirect = 1'b0;
      instr_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_seq(input int n, input int rd_at, input logic [31:0] tgt, input int rdy_from);
      for (int k = 0; k < n; k++) begin
         instr_ready = k >= rdy_from;
         redirect = k == rd_at;
         target = tgt;
         #1;
         h_req[k] = imem_req; h_addr[k] = imem_addr; h_valid[k] = instr_valid; h_pcen[k] = pc_en;
         h_ipc[k] = instr_pc; h_instr[k] = instr; h_ferr[k] = fetch_err;
         @(negedge clk);
      end
      redirect = 1'b0;
      instr_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; redirect = 1'b0; instr_ready = 1'b0; target = '0; rst_pc = '0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if ({imem_req, pc_en, instr_valid, fetch_err} !== 4'b0) begin n_err++; $display("FAIL reset_flags got=%b want=0000", {imem_req, pc_en, instr_valid, fetch_err}); end
      n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got=%h want=0", imem_addr); end
      n_cmp++; if ({instr, instr_pc} !== 64'h0) begin n_err++; $display("FAIL reset_instr got=%h/%h want=0", instr, instr_pc); end
   endtask

   task automatic test_stream;
      int nv = 0, np = 0;
      lat = 0;
      do_reset(32'h0);
      run_seq(10, -1, 32'h0, 0);
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if ({h_valid[3+3*i], h_ipc[3+3*i]} !== {1'b1, 32'(4*i)}) begin n_err++; $display("FAIL stream_pc%0d got=%b/%h want=1/%h", i, h_valid[3+3*i], h_ipc[3+3*i], 4*i); end
         n_cmp++; if (h_instr[3+3*i] !== mem_word(32'(4*i))) begin n_err++; $display("FAIL stream_instr%0d got=%h want=%h", i, h_instr[3+3*i], mem_word(32'(4*i))); end
      end
      for (int k = 0; k < 10; k++) begin
         if (h_valid[k]) nv++;
         if (h_pcen[k]) np++;
      end
      n_cmp++; if (nv !== 3) begin n_err++; $display("FAIL stream_valid_cnt got=%0d want=3", nv); end
      n_cmp++; if (np !== 3) begin n_err++; $display("FAIL stream_pcen_cnt got=%0d want=3", np); end
   endtask

   task automatic test_stall;
      int nr = 0, nv = 0, np = 0;
      lat = 3;
      do_reset(32'h100);
      run_seq(12, -1, 32'h0, 11);
      for (int k = 0; k < 12; k++) begin
         if (h_req[k]) begin
            nr++;
            n_cmp++; if (h_addr[k] !== 32'h100) begin n_err++; $display("FAIL stall_addr k=%0d got=%h want=100", k, h_addr[k]); end
         end
         if (h_valid[k]) begin
            nv++;
            n_cmp++; if ({h_ipc[k], h_instr[k]} !== {32'h100, mem_word(32'h100)}) begin n_err++; $display("FAIL stall_hold k=%0d got=%h/%h", k, h_ipc[k], h_instr[k]); end
         end
         if (h_pcen[k]) np++;
      end
      n_cmp++; if (nr !== 4) begin n_err++; $display("FAIL stall_req_cnt got=%0d want=4", nr); end
      n_cmp++; if (nv !== 6) begin n_err++; $display("FAIL stall_valid_cnt got=%0d want=6", nv); end
      n_cmp++; if (np !== 1) begin n_err++; $display("FAIL stall_pcen_cnt got=%0d want=1", np); end
   endtask

   task automatic test_redirect_wait;
      int np = 0;
      lat = 4;
      do_reset(32'h20);
      run_seq(14, 3, 32'h40, 0);
      for (int k = 2; k < 7; k++) begin
         n_cmp++; if ({h_req[k], h_addr[k]} !== {1'b1, 32'h20}) begin n_err++; $display("FAIL drain_req k=%0d got=%b/%h want=1/20", k, h_req[k], h_addr[k]); end
      end
      for (int k = 0; k < 12; k++) if (h_pcen[k] || h_valid[k]) np++;
      n_cmp++; if (np !== 0) begin n_err++; $display("FAIL drain_stale got=%0d want=0", np); end
      n_cmp++; if ({h_req[7], h_req[8], h_addr[8]} !== {2'b01, 32'h40}) begin n_err++; $display("FAIL drain_reissue got=%b%b/%h want=01/40", h_req[7], h_req[8], h_addr[8]); end
      n_cmp++; if ({h_valid[13], h_ipc[13], h_instr[13]} !== {1'b1, 32'h40, mem_word(32'h40)}) begin n_err++; $display("FAIL drain_instr got=%b/%h/%h want=1/40", h_valid[13], h_ipc[13], h_instr[13]); end
   endtask

   task automatic test_redirect_ack;
      lat = 2;
      do_reset(32'h30);
      run_seq(10, 4, 32'h80, 0);
      n_cmp++; if (h_pcen[4] !== 1'b0) begin n_err++; $display("FAIL ack_redir_pcen got=%b want=0", h_pcen[4]); end
      n_cmp++; if ({h_valid[5], h_req[5]} !== 2'b00) begin n_err++; $display("FAIL ack_redir_drop got=%b want=00", {h_valid[5], h_req[5]}); end
      n_cmp++; if ({h_req[6], h_addr[6]} !== {1'b1, 32'h80}) begin n_err++; $display("FAIL ack_redir_addr got=%b/%h want=1/80", h_req[6], h_addr[6]); end
      n_cmp++; if ({h_valid[9], h_ipc[9], h_instr[9]} !== {1'b1, 32'h80, mem_word(32'h80)}) begin n_err++; $display("FAIL ack_redir_instr got=%b/%h/%h want=1/80", h_valid[9], h_ipc[9], h_instr[9]); end
   endtask

   task automatic test_redirect_hold;
      int np = 0;
      lat = 0;
      do_reset(32'h50);
      run_seq(9, 4, 32'h90, 99);
      n_cmp++; if ({h_valid[4], h_instr[4]} !== {1'b1, mem_word(32'h50)}) begin n_err++; $display("FAIL hold_redir_pre got=%b/%h", h_valid[4], h_instr[4]); end
      n_cmp++; if (h_valid[5] !== 1'b0) begin n_err++; $display("FAIL hold_redir_fall got=%b want=0", h_valid[5]); end
      n_cmp++; if ({h_req[6], h_addr[6]} !== {1'b1, 32'h90}) begin n_err++; $display("FAIL hold_redir_addr got=%b/%h want=1/90", h_req[6], h_addr[6]); end
      n_cmp++; if ({h_valid[7], h_ipc[7], h_instr[7]} !== {1'b1, 32'h90, mem_word(32'h90)}) begin n_err++; $display("FAIL hold_redir_instr got=%b/%h/%h want=1/90", h_valid[7], h_ipc[7], h_instr[7]); end
      for (int k = 0; k < 9; k++) if (h_pcen[k]) np++;
      n_cmp++; if (np !== 2) begin n_err++; $display("FAIL hold_redir_pcen got=%0d want=2", np); end
   endtask

   task automatic test_rst_mid;
      lat = 0;
      do_reset(32'h10);
      run_seq(5, -1, 32'h0, 99);
      lat = 5;
      run_seq(4, -1, 32'h0, 0);
      rst_pc = 32'h200;
      rst = 1'b1;
      #1;
      n_cmp++; if ({imem_req, pc_en, instr_valid, fetch_err} !== 4'b0) begin n_err++; $display("FAIL rst_mid_flags got=%b want=0000", {imem_req, pc_en, instr_valid, fetch_err}); end
      n_cmp++; if ({imem_addr, instr, instr_pc} !== 96'h0) begin n_err++; $display("FAIL rst_mid_data got=%h/%h/%h want=0", imem_addr, instr, instr_pc); end
      @(negedge clk);
      rst = 1'b0;
      lat = 0;
      run_seq(5, -1, 32'h0, 0);
      n_cmp++; if ({h_req[2], h_addr[2]} !== {1'b1, 32'h200}) begin n_err++; $display("FAIL rst_mid_restart got=%b/%h want=1/200", h_req[2], h_addr[2]); end
      n_cmp++; if ({h_valid[3], h_ipc[3]} !== {1'b1, 32'h200}) begin n_err++; $display("FAIL rst_mid_instr got=%b/%h want=1/200", h_valid[3], h_ipc[3]); end
   endtask

   task automatic test_align;
      lat = 0;
      do_reset(32'h6);
`ifdef FETCH_ALIGN_CHECK_EN
      run_seq(8, 3, 32'h8, 0);
      n_cmp++; if ({h_ferr[2], h_req[2], h_ferr[3], h_req[3], h_pcen[3]} !== 5'b10100) begin n_err++; $display("FAIL align_err got=%b want=10100", {h_ferr[2], h_req[2], h_ferr[3], h_req[3], h_pcen[3]}); end
      n_cmp++; if (h_ferr[4] !== 1'b0) begin n_err++; $display("FAIL align_clear got=%b want=0", h_ferr[4]); end
      n_cmp++; if ({h_req[5], h_addr[5]} !== {1'b1, 32'h8}) begin n_err++; $display("FAIL align_resume got=%b/%h want=1/8", h_req[5], h_addr[5]); end
      n_cmp++; if ({h_valid[6], h_ipc[6]} !== {1'b1, 32'h8}) begin n_err++; $display("FAIL align_instr got=%b/%h want=1/8", h_valid[6], h_ipc[6]); end
`else
      run_seq(5, -1, 32'h0, 0);
      n_cmp++; if ({h_req[2], h_addr[2]} !== {1'b1, 32'h4}) begin n_err++; $display("FAIL align_mask got=%b/%h want=1/4", h_req[2], h_addr[2]); end
      n_cmp++; if ({h_ipc[3], h_instr[3]} !== {32'h6, mem_word(32'h4)}) begin n_err++; $display("FAIL align_pc got=%h/%h want=6", h_ipc[3], h_instr[3]); end
      n_cmp++; if ({h_ferr[1], h_ferr[2], h_ferr[3]} !== 3'b0) begin n_err++; $display("FAIL align_ferr got=%b want=0", {h_ferr[1], h_ferr[2], h_ferr[3]}); end
`endif
   endtask

   // model: the next instruction to reach decode is at exp_pc, which steps by 4 per transfer and jumps on redirect
   task automatic test_random;
      logic [31:0] exp_pc = '0, prev_addr = '0;
      logic prev_req = 1'b0, prev_ack = 1'b0, prev_pcen = 1'b0;
      do_reset(32'h0);
      for (int c = 0; c < 2000; c++) begin
         lat = $urandom_range(0, 4);
         instr_ready = $urandom_range(0, 9) < 7;
         redirect = $urandom_range(0, 19) == 0;
         target = $urandom_range(0, 255) << 2;
         #1;
         if (redirect) begin
            n_cmp++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL rnd_pcen_redir c=%0d got=%b want=0", c, pc_en); end
         end
         if (prev_pcen) begin
            n_cmp++; if ({instr_valid, instr_pc} !== {1'b1, prev_addr}) begin n_err++; $display("FAIL rnd_capture c=%0d got=%b/%h want=1/%h", c, instr_valid, instr_pc, prev_addr); end
         end
         if (imem_req && !prev_req) begin
            n_cmp++; if (imem_addr !== exp_pc) begin n_err++; $display("FAIL rnd_req_addr c=%0d got=%h want=%h", c, imem_addr, exp_pc); end
         end
         if (imem_req && prev_req && !prev_ack) begin
            n_cmp++; if (imem_addr !== prev_addr) begin n_err++; $display("FAIL rnd_addr_stable c=%0d got=%h want=%h", c, imem_addr, prev_addr); end
         end
         if (instr_valid && instr_ready) begin
            n_cmp++; if ({instr_pc, instr} !== {exp_pc, mem_word(exp_pc)}) begin n_err++; $display("FAIL rnd_xfer c=%0d got=%h/%h want=%h/%h", c, instr_pc, instr, exp_pc, mem_word(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
         end
         n_cmp++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL rnd_ferr c=%0d got=%b want=0", c, fetch_err); end
         if (redirect) exp_pc = target;
         prev_req = imem_req;
         prev_ack = imem_ack;
         prev_pcen = pc_en;
         prev_addr = imem_addr;
         @(negedge clk);
      end
      redirect = 1'b0;
   endtask

   initial begin
      test_reset;
      test_stream;
      test_stall;
      test_redirect_wait;
      test_redirect_ack;
      test_redirect_hold;
      test_rst_mid;
      test_align;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
